// File: rtl/fifo_spram_ctrl.sv
// Valid/ready FIFO controller for a single-port RAM bank with 1-cycle read latency and a 2-entry output buffer.
// Latency: bank write to out_valid is at least 3 cycles. Backpressure: in_ready drops when the bank is full or busy.
module fifo_spram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  bank_wen,
    output logic [ADDR_WIDTH-1:0] bank_waddr,
    output logic [DATA_WIDTH-1:0] bank_wdata,
    output logic                  bank_ren,
    output logic [ADDR_WIDTH-1:0] bank_raddr,
    input  logic [DATA_WIDTH-1:0] bank_rdata,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q, count_d, mem_used;
    logic                  busy_q, busy_d, inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] obuf_q [2];
    logic [DATA_WIDTH-1:0] obuf_d [2];
    logic                  obuf_rd_q, obuf_rd_d, obuf_wr_q, obuf_wr_d;
    logic [1:0]            obuf_cnt_q, obuf_cnt_d;
    logic [2:0]            credit;
    logic                  push, pop, read_go;

    always_comb begin
        mem_used  = wr_ptr_q - rd_ptr_q;
        // mem_used never exceeds DEPTH, so its MSB alone flags full
        in_ready  = rst_n & ~busy_q & ~mem_used[ADDR_WIDTH];
        out_valid = rst_n & (obuf_cnt_q != 2'd0);
        out_data  = obuf_q[obuf_rd_q];
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        // slots the output buffer will need after this cycle, including the read in flight
        credit    = {1'b0, obuf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        read_go   = rst_n & ~busy_q & (mem_used != '0) & (credit < 3'd2);

        bank_wen   = push;
        bank_waddr = wr_ptr_q[ADDR_WIDTH-1:0];
        bank_wdata = in_data;
        bank_ren   = read_go;
        bank_raddr = rd_ptr_q[ADDR_WIDTH-1:0];

        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(read_go);
        busy_d     = push & read_go;
        inflight_d = read_go;

        obuf_d = obuf_q;
        if (inflight_q) begin
            obuf_d[obuf_wr_q] = bank_rdata;
        end
        obuf_wr_d  = obuf_wr_q ^ inflight_q;
        obuf_rd_d  = obuf_rd_q ^ pop;
        obuf_cnt_d = obuf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

        count_d = (wr_ptr_d - rd_ptr_d) + PW'(inflight_d) + PW'(obuf_cnt_d);
        count   = rst_n ? count_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            inflight_q <= 1'b0;
            obuf_q[0]  <= '0;
            obuf_q[1]  <= '0;
            obuf_rd_q  <= 1'b0;
            obuf_wr_q  <= 1'b0;
            obuf_cnt_q <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            obuf_q[0]  <= obuf_d[0];
            obuf_q[1]  <= obuf_d[1];
            obuf_rd_q  <= obuf_rd_d;
            obuf_wr_q  <= obuf_wr_d;
            obuf_cnt_q <= obuf_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_spram_ctrl.sv
// Directed vector table plus scoreboarded multi-cycle sequences for fifo_spram_ctrl, with a behavioural bank.
module tb_fifo_spram_ctrl;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, bank_wen, bank_ren;
    logic [DW-1:0] out_data, bank_wdata;
    logic [DW-1:0] bank_rdata = '0;
    logic [AW-1:0] bank_waddr, bank_raddr;
    logic [AW:0]   count;

    fifo_spram_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bank_wen(bank_wen), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
        .bank_ren(bank_ren), .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
        .count(count)
    );

    always #5 clk = ~clk;

    // Bank: a write colliding with a read is committed one cycle later
    logic [DW-1:0] mem [DEPTH];
    logic          pend_vld = 1'b0;
    logic [AW-1:0] pend_a = '0;
    logic [DW-1:0] pend_d = '0;
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        pend_vld <= 1'b0;
        if (pend_vld) mem[pend_a] <= pend_d;
        if (bank_ren) bank_rdata <= mem[bank_raddr];
        if (bank_wen && bank_ren) begin
            pend_vld <= 1'b1;
            pend_a   <= bank_waddr;
            pend_d   <= bank_wdata;
        end else if (bank_wen) begin
            mem[bank_waddr] <= bank_wdata;
        end
    end

    int vec_cnt = 0;
    int miss_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          rst, iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_ir, e_ov, e_wen, e_ren;
        int            e_cnt;
        logic          chk_d;
        logic [DW-1:0] e_d;
    } vec_t;
    vec_t tbl [25];

    logic [DW-1:0] q [$];
    int  held = 0, occ = 0, outstanding = 0;
    bit  prev_coll = 0;

    task automatic step(input string tag, output bit acc);
        logic s_wen, s_ren, s_pop;
        logic [DW-1:0] exp_d;
        #2;
        chk({tag, "_count"}, 32'(count), 32'(held));
        if (prev_coll) begin
            chk({tag, "_busy_wen"}, 32'(bank_wen), 0);
            chk({tag, "_busy_ren"}, 32'(bank_ren), 0);
            chk({tag, "_busy_ird"}, 32'(in_ready), 0);
        end
        chk({tag, "_full_wr"}, 32'(bank_wen && occ == DEPTH), 0);
        chk({tag, "_obuf_ovf"}, 32'(outstanding <= 2), 1);
        acc   = in_valid && in_ready;
        s_pop = out_valid && out_ready;
        s_wen = bank_wen;
        s_ren = bank_ren;
        if (s_pop) begin
            if (q.size() == 0) chk({tag, "_spurious_pop"}, 1, 0);
            else begin
                exp_d = q.pop_front();
                chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
            end
        end
        if (acc) q.push_back(in_data);
        @(posedge clk);
        held        = held + int'(acc) - int'(s_pop);
        occ         = occ + int'(s_wen) - int'(s_ren);
        outstanding = outstanding + int'(s_ren) - int'(s_pop);
        prev_coll   = s_wen && s_ren;
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int sent, cyc;
        // rst iv d ordy | ir ov wen ren cnt | chk_d e_d
        tbl[0]  = '{0,1,8'h00,0, 0,0,0,0,0, 0,8'h00};
        tbl[1]  = '{0,1,8'h00,0, 0,0,0,0,0, 0,8'h00};
        tbl[2]  = '{0,1,8'h00,0, 0,0,0,0,0, 0,8'h00};
        tbl[3]  = '{1,0,8'h00,0, 1,0,0,0,0, 0,8'h00};
        tbl[4]  = '{1,1,8'h11,0, 1,0,1,0,0, 0,8'h00};
        tbl[5]  = '{1,1,8'hA5,0, 1,0,1,1,1, 0,8'h00};
        tbl[6]  = '{1,0,8'h00,0, 0,0,0,0,2, 0,8'h00};
        tbl[7]  = '{1,0,8'h00,0, 1,1,0,1,2, 1,8'h11};
        tbl[8]  = '{1,0,8'h00,0, 1,1,0,0,2, 1,8'h11};
        tbl[9]  = '{1,0,8'h00,1, 1,1,0,0,2, 1,8'h11};
        tbl[10] = '{1,0,8'h00,1, 1,1,0,0,1, 1,8'hA5};
        tbl[11] = '{1,0,8'h00,0, 1,0,0,0,0, 0,8'h00};
        tbl[12] = '{1,1,8'h01,0, 1,0,1,0,0, 0,8'h00};
        tbl[13] = '{1,1,8'h02,0, 1,0,1,1,1, 0,8'h00};
        tbl[14] = '{1,1,8'h03,0, 0,0,0,0,2, 0,8'h00};
        tbl[15] = '{1,1,8'h03,0, 1,1,1,1,2, 1,8'h01};
        tbl[16] = '{1,1,8'h04,0, 0,1,0,0,3, 1,8'h01};
        tbl[17] = '{1,1,8'h04,0, 1,1,1,0,3, 1,8'h01};
        tbl[18] = '{1,1,8'h05,0, 1,1,1,0,4, 1,8'h01};
        tbl[19] = '{0,0,8'h00,0, 0,0,0,0,0, 0,8'h00};
        tbl[20] = '{1,1,8'h5A,0, 1,0,1,0,0, 0,8'h00};
        tbl[21] = '{1,0,8'h00,0, 1,0,0,1,1, 0,8'h00};
        tbl[22] = '{1,0,8'h00,0, 1,0,0,0,1, 0,8'h00};
        tbl[23] = '{1,0,8'h00,1, 1,1,0,0,1, 1,8'h5A};
        tbl[24] = '{1,0,8'h00,0, 1,0,0,0,0, 0,8'h00};

        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            rst_n = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
            #2;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d_bank_wen", i), 32'(bank_wen), 32'(tbl[i].e_wen));
            chk($sformatf("v%0d_bank_ren", i), 32'(bank_ren), 32'(tbl[i].e_ren));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            if (tbl[i].chk_d) chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_d));
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 0; out_ready = 0;
        held = 0; occ = 0; outstanding = 0; prev_coll = 0;

        // Fill to DEPTH+2 with the output stalled, then drain
        cyc = 0;
        while (q.size() < DEPTH + 2 && cyc < 300) begin
            in_valid = 1; in_data = DW'(q.size());
            step("fill", acc);
            cyc++;
        end
        if (cyc >= 300) chk("fill_timeout", 0, 1);
        in_valid = 0;
        for (int i = 0; i < 4; i++) step("settle", acc);
        in_valid = 1; in_data = 8'h99;
        #1;
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_count", 32'(count), DEPTH + 2);
        in_valid = 0;
        out_ready = 1; cyc = 0;
        while (q.size() != 0 && cyc < 300) begin
            step("drain", acc);
            cyc++;
        end
        if (cyc >= 300) chk("drain_timeout", 0, 1);
        out_ready = 0;
        step("drained", acc);
        #2;
        chk("drained_out_valid", 32'(out_valid), 0);
        chk("drained_count", 32'(count), 0);
        @(negedge clk);

        // Streaming push and pop together
        sent = 0; cyc = 0; out_ready = 1;
        while ((sent < 100 || q.size() != 0) && cyc < 2000) begin
            in_valid = (sent < 100); in_data = DW'(sent + 8'h20);
            step("stream", acc);
            if (acc) sent++;
            cyc++;
        end
        if (cyc >= 2000) chk("stream_timeout", 0, 1);
        in_valid = 0; out_ready = 0;

        // Random valid/ready against the scoreboard
        sent = 0; cyc = 0;
        while ((sent < 2000 || q.size() != 0) && cyc < 40000) begin
            in_valid  = (sent < 2000) && ($urandom_range(1) == 1);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(1) == 1);
            step("rand", acc);
            if (acc) sent++;
            cyc++;
        end
        if (cyc >= 40000) chk("rand_timeout", 0, 1);
        in_valid = 0; out_ready = 0;
        step("final", acc);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
